wave_plotter: RTL and testbench
===============================

# wave_plotter

Multi-channel parametrised waveform point generator for the VGA plotting path. Per frame it sweeps a horizontal coordinate from 0 to X_MAX and, for each X, emits one point per channel. Each point carries a Y value from that channel's phase accumulator, shaped by a per-channel mode: ROM lookup, ramp, triangle or square. The point stream (x, y, channel, colour) feeds the downstream frame-buffer writer; the ROM port connects to the existing synchronous sine ROM.

## Interface
- X_W, 8: width of pt_x.
- X_MAX, 159: last X of a frame; X_MAX < 2^X_W.
- Y_W, 8: width of pt_y and rom_q.
- PH_W, 10: phase accumulator width; PH_W >= Y_W+1.
- NCH, 2: channel count, >= 1.
- COLOR_W, 12: colour width.
- CH_W, $clog2(NCH) (min 1): width of pt_ch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lock  in  1  run enable (PLL lock); 0 holds the scan at frame start.
- cfg_mode  in  2*NCH  per-channel mode, ch0 in the LSBs: 0 ROM, 1 ramp, 2 triangle, 3 square.
- cfg_inc  in  PH_W*NCH  per-channel phase increment per X step.
- cfg_ofs  in  PH_W*NCH  per-channel phase at X=0.
- cfg_color  in  COLOR_W*NCH  per-channel colour.
- rom_addr  out  PH_W  ROM address (combinational from registered state).
- rom_q  in  Y_W  ROM data, valid the cycle after rom_addr is presented.
- pt_valid  out  1  point strobe.
- pt_x  out  X_W  point X.
- pt_y  out  Y_W  point Y.
- pt_ch  out  CH_W  point channel.
- pt_color  out  COLOR_W  point colour.
- pt_last  out  1  high with the frame's final point (x=X_MAX, ch=NCH-1).

## Operation
- Scan state: registered (x, ch) plus NCH phase registers. Each enabled cycle advances ch. At ch=NCH-1, ch wraps to 0 and x increments. At (X_MAX, NCH-1), the scan wraps to (0,0).
- Phase update: when x advances, every phase[c] += inc[c], modulo 2^PH_W. On wrap to a new frame, phase[c] reloads ofs[c].
- Shadow config: cfg_mode, cfg_inc, cfg_ofs and cfg_color are copied into shadow registers when a frame starts (scan at (0,0) leaving reset or lock-low, or on frame wrap). Mid-frame config changes have no effect until the next frame.
- rom_addr = phase[ch] for the current scan step.
- Stage 1 registers x, ch, phase, mode and colour for the step. While stage 1 holds a valid step, Y is formed from that step's phase p (PH_W bits) and mode:
  - ROM: y = rom_q.
  - ramp: y = p[PH_W-1 -: Y_W].
  - triangle: t = p[PH_W-2 -: Y_W]; y = p[PH_W-1] ? ~t : t.
  - square: y = p[PH_W-1] ? 0 : all ones.
- Output registers capture the stage-1 result, and pt_valid follows stage-1 valid.
- lock=0, sampled at a clock edge:
  - scan forced to (0,0), phases reloaded from cfg_ofs, shadows reloaded;
  - stage-1 valid cleared, so the in-flight point is dropped;
  - pt_valid=0 from the next cycle.
- lock returning to 1 starts a fresh frame at (0,0).

## Timing
- Reset (rst_n low, asynchronous): pt_* = 0, pt_valid = 0, pt_last = 0, x = ch = 0, phases = 0, rom_addr = 0, stage-1 valid = 0. The first enabled edge after reset loads phases and shadows from cfg; scanning begins on the following cycle.
- Latency: a step presented on rom_addr in cycle n appears on pt_* in cycle n+2.
- Throughput: one point per cycle while lock=1; no bubbles at channel, X or frame wrap.
- Frame period: (X_MAX+1)*NCH cycles; pt_last pulses once per frame for exactly one cycle.
- rst_n asserted mid-frame: immediate clear, identical to the reset values above.

## Test plan
- Reset and lock low: rst_n=0 then 1 with lock=0 for 10 cycles -> pt_valid=0 throughout. Raise lock -> the first point, pt_x=0, pt_ch=0, appears 2 cycles after scanning starts.
- Ramp and frame length: NCH=2, ch0 mode 1, inc=4, ofs=0 -> ch0 points have pt_y=pt_x for x=0..159. Exactly 320 pt_valid cycles per frame; pt_last only at x=159, ch=1.
- Triangle and square: ch0 triangle, ch1 square, both inc=8, ofs=0.
  - Triangle (ch0) -> y=128 at x=32, y=252 at x=63, y=255 at x=64.
  - Square (ch1) -> y=255 for x 0..63, y=0 for x 64..127.
- ROM latency: bench ROM q = addr[7:0]^8'h55, ch0 mode 0, inc=1, ofs=3 -> pt_y at x=k equals (k+3)^8'h55.
- Shadowing: change ch0 inc from 4 to 8 at x=80 -> the current frame keeps inc 4; the next frame uses 8 (pt_y=2x mod 256 at x=10 gives 20).
- Lock drop mid-frame: lock=0 at x=50 -> pt_valid=0 from the next cycle. Restore lock -> the scan restarts at x=0 with phases equal to cfg_ofs.

Source files
------------

// File: rtl/wave_plotter.sv
// Multi-channel waveform point generator: sweeps X across a frame and emits one
// (x, y, channel, colour) point per channel per X, with Y shaped per channel mode.
module wave_plotter #(
    parameter int X_W     = 8,
    parameter int X_MAX   = 159,
    parameter int Y_W     = 8,
    parameter int PH_W    = 10,
    parameter int NCH     = 2,
    parameter int COLOR_W = 12,
    parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lock,
    input  logic [2*NCH-1:0]        cfg_mode,
    input  logic [PH_W*NCH-1:0]     cfg_inc,
    input  logic [PH_W*NCH-1:0]     cfg_ofs,
    input  logic [COLOR_W*NCH-1:0]  cfg_color,
    output logic [PH_W-1:0]         rom_addr,
    input  logic [Y_W-1:0]          rom_q,
    output logic                    pt_valid,
    output logic [X_W-1:0]          pt_x,
    output logic [Y_W-1:0]          pt_y,
    output logic [CH_W-1:0]         pt_ch,
    output logic [COLOR_W-1:0]      pt_color,
    output logic                    pt_last
);

    localparam logic [X_W-1:0]  X_LAST  = X_W'(X_MAX);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    localparam logic [1:0] MODE_ROM  = 2'd0;
    localparam logic [1:0] MODE_RAMP = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;

    function automatic logic [Y_W-1:0] shape_y(input logic [1:0]      mode,
                                               input logic [PH_W-1:0] p,
                                               input logic [Y_W-1:0]  q);
        logic [Y_W-1:0] t;
        t = p[PH_W-2 -: Y_W];
        case (mode)
            MODE_ROM:  shape_y = q;
            MODE_RAMP: shape_y = p[PH_W-1 -: Y_W];
            MODE_TRI:  shape_y = p[PH_W-1] ? ~t : t;
            default:   shape_y = p[PH_W-1] ? {Y_W{1'b0}} : {Y_W{1'b1}};
        endcase
    endfunction

    // ---- p0: scan position, phase accumulators, shadow configuration ----
    logic [X_W-1:0]     x_p0;
    logic [CH_W-1:0]    ch_p0;
    logic [PH_W-1:0]    phase_p0 [NCH];
    logic               run_p0;
    logic [1:0]         mode_sh  [NCH];
    logic [PH_W-1:0]    inc_sh   [NCH];
    logic [COLOR_W-1:0] color_sh [NCH];

    logic step_p0, last_p0, load_p0;

    // run_p0 marks that phases/shadows were loaded on a previous lock-high edge
    assign step_p0  = run_p0 & lock;
    assign last_p0  = (x_p0 == X_LAST) && (ch_p0 == CH_LAST);
    assign load_p0  = !step_p0 || last_p0;
    assign rom_addr = phase_p0[ch_p0];

    logic vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p0   <= '0;
            ch_p0  <= '0;
            run_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            for (int c = 0; c < NCH; c++) phase_p0[c] <= '0;
        end else if (!step_p0) begin
            x_p0   <= '0;
            ch_p0  <= '0;
            run_p0 <= lock;
            vld_p1 <= 1'b0;
            for (int c = 0; c < NCH; c++) phase_p0[c] <= cfg_ofs[c*PH_W +: PH_W];
        end else begin
            vld_p1 <= 1'b1;
            if (ch_p0 == CH_LAST) begin
                ch_p0 <= '0;
                if (x_p0 == X_LAST) begin
                    x_p0 <= '0;
                    for (int c = 0; c < NCH; c++) phase_p0[c] <= cfg_ofs[c*PH_W +: PH_W];
                end else begin
                    x_p0 <= x_p0 + X_W'(1);
                    for (int c = 0; c < NCH; c++) phase_p0[c] <= phase_p0[c] + inc_sh[c];
                end
            end else begin
                ch_p0 <= ch_p0 + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_p0) begin
            for (int c = 0; c < NCH; c++) begin
                mode_sh[c]  <= cfg_mode[2*c +: 2];
                inc_sh[c]   <= cfg_inc[c*PH_W +: PH_W];
                color_sh[c] <= cfg_color[c*COLOR_W +: COLOR_W];
            end
        end
    end

    // ---- p1: step registered alongside the synchronous ROM read ----
    logic [X_W-1:0]     x_p1;
    logic [CH_W-1:0]    ch_p1;
    logic [PH_W-1:0]    ph_p1;
    logic [1:0]         mode_p1;
    logic [COLOR_W-1:0] color_p1;
    logic               last_p1;

    always_ff @(posedge clk) begin
        if (step_p0) begin
            x_p1     <= x_p0;
            ch_p1    <= ch_p0;
            ph_p1    <= rom_addr;
            mode_p1  <= mode_sh[ch_p0];
            color_p1 <= color_sh[ch_p0];
            last_p1  <= last_p0;
        end
    end

    // ---- p2: output registers; lock low suppresses the in-flight point ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_valid <= 1'b0;
            pt_last  <= 1'b0;
            pt_x     <= '0;
            pt_y     <= '0;
            pt_ch    <= '0;
            pt_color <= '0;
        end else begin
            pt_valid <= lock & vld_p1;
            pt_last  <= lock & vld_p1 & last_p1;
            if (lock && vld_p1) begin
                pt_x     <= x_p1;
                pt_y     <= shape_y(mode_p1, ph_p1, rom_q);
                pt_ch    <= ch_p1;
                pt_color <= color_p1;
            end
        end
    end

endmodule

// File: tb/tb_wave_plotter.sv
// Scoreboard bench for wave_plotter: expected frames are queued as the scan is
// started and compared point by point as the DUT emits them.
module tb_wave_plotter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock = 1'b0;
    logic [3:0]  cfg_mode = '0;
    logic [19:0] cfg_inc = '0;
    logic [19:0] cfg_ofs = '0;
    logic [23:0] cfg_color = {12'h0F0, 12'hF00};
    logic [9:0]  rom_addr;
    logic [7:0]  rom_q = '0;
    logic        pt_valid, pt_last, pt_ch;
    logic [7:0]  pt_x, pt_y;
    logic [11:0] pt_color;

    wave_plotter dut (
        .clk(clk), .rst_n(rst_n), .lock(lock),
        .cfg_mode(cfg_mode), .cfg_inc(cfg_inc), .cfg_ofs(cfg_ofs), .cfg_color(cfg_color),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ch(pt_ch),
        .pt_color(pt_color), .pt_last(pt_last)
    );

    always #5 clk = ~clk;

    // synchronous sine-ROM stand-in
    always @(posedge clk) rom_q <= rom_addr[7:0] ^ 8'h55;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        ch;
        logic [11:0] color;
        logic        last;
    } pt_t;

    pt_t        exp_q[$];
    pt_t        mon_e;
    int         errors = 0;
    int         checks = 0;
    int         vcount = 0;
    int         lcount = 0;
    logic [7:0] ylog [2][160];

    function automatic logic [7:0] model_y(input logic [1:0] m, input int ph);
        int h;
        h = ph / 2;
        case (m)
            2'd0:    model_y = 8'(ph % 256) ^ 8'h55;
            2'd1:    model_y = 8'(ph / 4);
            2'd2:    model_y = (ph < 512) ? 8'(h) : 8'(255 - (h % 256));
            default: model_y = (ph < 512) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] m0, input logic [1:0] m1,
                              input int inc0, input int inc1, input int ofs0, input int ofs1);
        pt_t e;
        for (int x = 0; x < 160; x++) begin
            for (int c = 0; c < 2; c++) begin
                int ph;
                ph = ((c == 0 ? ofs0 : ofs1) + x * (c == 0 ? inc0 : inc1)) % 1024;
                e.x     = 8'(x);
                e.y     = model_y(c == 0 ? m0 : m1, ph);
                e.ch    = (c == 1);
                e.color = (c == 0) ? 12'hF00 : 12'h0F0;
                e.last  = (x == 159) && (c == 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_cfg(input logic [1:0] m0, input logic [1:0] m1,
                           input int inc0, input int inc1, input int ofs0, input int ofs1);
        cfg_mode = {m1, m0};
        cfg_inc  = {10'(inc1), 10'(inc0)};
        cfg_ofs  = {10'(ofs1), 10'(ofs0)};
    endtask

    task automatic idle();
        lock = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        exp_q.delete();
        vcount = 0;
        lcount = 0;
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout got %0d points outstanding, required 0", exp_q.size());
        end
        lock = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && pt_valid) begin
            vcount++;
            if (pt_last) lcount++;
            if (pt_x < 8'd160) ylog[pt_ch][pt_x] = pt_y;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_point got x=%0d ch=%0d y=%0d, required no point",
                         pt_x, pt_ch, pt_y);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pt_x, pt_y, pt_ch, pt_color, pt_last} !== mon_e) begin
                    errors++;
                    $display("FAIL point got x=%0d y=%0d ch=%0d color=%h last=%0d, required x=%0d y=%0d ch=%0d color=%h last=%0d",
                             pt_x, pt_y, pt_ch, pt_color, pt_last,
                             mon_e.x, mon_e.y, mon_e.ch, mon_e.color, mon_e.last);
                end
            end
        end
    end

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        lock  = 1'b0;
        set_cfg(2'd1, 2'd1, 4, 4, 12, 20);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({pt_valid, pt_last, pt_x, pt_y, pt_ch, pt_color, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state got valid=%0d last=%0d x=%0d y=%0d ch=%0d color=%h addr=%0d, required all 0",
                     pt_valid, pt_last, pt_x, pt_y, pt_ch, pt_color, rom_addr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pt_valid !== 1'b0) begin
                errors++;
                $display("FAIL lock_low_valid got %0d, required 0 (cycle %0d)", pt_valid, i);
            end
        end
        exp_q.delete();
        push_frame(2'd1, 2'd1, 4, 4, 12, 20);
        lock = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            #1;
            n++;
            if (pt_valid === 1'b1) break;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL first_point_latency got %0d cycles, required 3", n);
        end
        checks++;
        if (pt_x !== 8'd0 || pt_ch !== 1'b0 || pt_y !== 8'd3) begin
            errors++;
            $display("FAIL first_point got x=%0d ch=%0d y=%0d, required x=0 ch=0 y=3", pt_x, pt_ch, pt_y);
        end
        drain(400, n);
        idle();
    endtask

    task automatic test_ramp_back_to_back();
        int n;
        int xs [4] = '{0, 1, 77, 159};
        set_cfg(2'd1, 2'd2, 4, 3, 0, 100);
        push_frame(2'd1, 2'd2, 4, 3, 0, 100);
        push_frame(2'd1, 2'd2, 4, 3, 0, 100);
        lock = 1'b1;
        drain(700, n);
        checks++;
        if (n !== 642) begin
            errors++;
            $display("FAIL two_frame_cycles got %0d, required 642", n);
        end
        checks++;
        if (vcount !== 640 || lcount !== 2) begin
            errors++;
            $display("FAIL frame_counts got valid=%0d last=%0d, required valid=640 last=2", vcount, lcount);
        end
        foreach (xs[i]) begin
            checks++;
            if (ylog[0][xs[i]] !== 8'(xs[i])) begin
                errors++;
                $display("FAIL ramp_y x=%0d got %0d, required %0d", xs[i], ylog[0][xs[i]], xs[i]);
            end
        end
        idle();
    endtask

    task automatic test_tri_square();
        int n;
        set_cfg(2'd2, 2'd3, 8, 8, 0, 0);
        push_frame(2'd2, 2'd3, 8, 8, 0, 0);
        lock = 1'b1;
        drain(400, n);
        checks++;
        if (ylog[0][32] !== 8'd128 || ylog[0][63] !== 8'd252 || ylog[0][64] !== 8'd255) begin
            errors++;
            $display("FAIL triangle got y32=%0d y63=%0d y64=%0d, required 128 252 255",
                     ylog[0][32], ylog[0][63], ylog[0][64]);
        end
        checks++;
        if (ylog[1][0] !== 8'd255 || ylog[1][63] !== 8'd255 || ylog[1][64] !== 8'd0 || ylog[1][127] !== 8'd0) begin
            errors++;
            $display("FAIL square got y0=%0d y63=%0d y64=%0d y127=%0d, required 255 255 0 0",
                     ylog[1][0], ylog[1][63], ylog[1][64], ylog[1][127]);
        end
        idle();
    endtask

    task automatic test_rom();
        int n;
        int ks [4] = '{0, 10, 100, 159};
        set_cfg(2'd0, 2'd1, 1, 5, 3, 7);
        push_frame(2'd0, 2'd1, 1, 5, 3, 7);
        lock = 1'b1;
        drain(400, n);
        foreach (ks[i]) begin
            checks++;
            if (ylog[0][ks[i]] !== (8'(ks[i] + 3) ^ 8'h55)) begin
                errors++;
                $display("FAIL rom_y x=%0d got %0d, required %0d", ks[i], ylog[0][ks[i]],
                         8'(ks[i] + 3) ^ 8'h55);
            end
        end
        idle();
    endtask

    task automatic test_shadow();
        int n;
        set_cfg(2'd1, 2'd1, 4, 2, 0, 0);
        push_frame(2'd1, 2'd1, 4, 2, 0, 0);
        push_frame(2'd1, 2'd1, 8, 2, 0, 0);
        lock = 1'b1;
        n = 0;
        while (n < 400 && !(pt_valid === 1'b1 && pt_x === 8'd80)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL shadow_reach_x80 got timeout after %0d cycles, required x=80", n);
        end
        cfg_inc[9:0] = 10'd8;
        checks++;
        if (ylog[0][10] !== 8'd10) begin
            errors++;
            $display("FAIL shadow_frame1 got y=%0d at x=10, required 10", ylog[0][10]);
        end
        drain(700, n);
        checks++;
        if (ylog[0][10] !== 8'd20) begin
            errors++;
            $display("FAIL shadow_frame2 got y=%0d at x=10, required 20", ylog[0][10]);
        end
        idle();
    endtask

    task automatic test_lock_drop();
        int n;
        set_cfg(2'd1, 2'd3, 4, 8, 40, 300);
        push_frame(2'd1, 2'd3, 4, 8, 40, 300);
        lock = 1'b1;
        n = 0;
        while (n < 400 && !(pt_valid === 1'b1 && pt_x === 8'd50 && pt_ch === 1'b0)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL lock_drop_reach_x50 got timeout after %0d cycles, required x=50", n);
        end
        lock = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (pt_valid !== 1'b0) begin
                errors++;
                $display("FAIL lock_drop_valid got %0d, required 0 (cycle %0d)", pt_valid, i);
            end
        end
        ylog[0][0] = 8'd0;
        vcount = 0;
        lcount = 0;
        push_frame(2'd1, 2'd3, 4, 8, 40, 300);
        lock = 1'b1;
        drain(400, n);
        checks++;
        if (ylog[0][0] !== 8'd10 || vcount !== 320 || lcount !== 1) begin
            errors++;
            $display("FAIL lock_restart got y0=%0d valid=%0d last=%0d, required y0=10 valid=320 last=1",
                     ylog[0][0], vcount, lcount);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        int n;
        set_cfg(2'd1, 2'd1, 4, 4, 40, 8);
        push_frame(2'd1, 2'd1, 4, 4, 40, 8);
        lock = 1'b1;
        n = 0;
        while (n < 400 && !(pt_valid === 1'b1 && pt_x === 8'd30)) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        exp_q.delete();
        lock = 1'b0;
        #1;
        checks++;
        if ({pt_valid, pt_last, pt_x, pt_y, pt_ch, pt_color, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid got valid=%0d x=%0d y=%0d ch=%0d color=%h addr=%0d, required all 0",
                     pt_valid, pt_x, pt_y, pt_ch, pt_color, rom_addr);
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pt_valid !== 1'b0 || rom_addr !== 10'd40) begin
            errors++;
            $display("FAIL reset_mid_reload got valid=%0d addr=%0d, required valid=0 addr=40", pt_valid, rom_addr);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_back_to_back();
        test_tri_square();
        test_rom();
        test_shadow();
        test_lock_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
